// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundles the CPU MEM-stage, DMA and DataMemory signals
// that pass through dmem_arbiter.
//   cpu_*  : MEM-stage request (rd/wr/addr/wdata) plus rdata/stall back
//   dma_*  : debug/DMA beat request (req/we/burst/addr/wdata) plus
//            gnt/rvalid/rdata back
//   mem_*  : DataMemory port (rd/wr/addr/wdata out, rdata in)
// Modports:
//   slave  : the arbiter itself
//   master : the surrounding system (pipeline, DMA engine, memory)
interface dmem_arbiter_if;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;

    logic        dma_req;
    logic        dma_we;
    logic        dma_burst;
    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
    logic        dma_gnt;
    logic        dma_rvalid;
    logic [31:0] dma_rdata;

    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  dma_req, dma_we, dma_burst, dma_addr, dma_wdata,
        output dma_gnt, dma_rvalid, dma_rdata,
        output mem_rd, mem_wr, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output dma_req, dma_we, dma_burst, dma_addr, dma_wdata,
        input  dma_gnt, dma_rvalid, dma_rdata,
        input  mem_rd, mem_wr, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single DataMemory port between the pipeline
// MEM stage (priority) and a debug/DMA master. A pending DMA beat that has
// been refused MAX_WAIT times is forced through, stalling the pipeline.
// DMA accesses to MMIO (addr >= 0x4000_0000) are granted as no-ops; such
// reads return 0.
// Ports:
//   sysclk : clock, all state on posedge
//   reset  : asynchronous, active-low
//   bus    : dmem_arbiter_if.slave (cpu_*, dma_*, mem_* groups)
// Parameters:
//   MAX_WAIT  : refusals before a forced DMA grant (>=1)
//   BURST_LEN : max beats per burst grant (>=2), used with MEM_ARB_BURST_EN
// Build option:
//   MEM_ARB_BURST_EN : when defined, a grant with dma_burst=1 holds the port
//                      for the DMA for up to BURST_LEN beats.
module dmem_arbiter #(
    parameter int unsigned MAX_WAIT  = 4,
    parameter int unsigned BURST_LEN = 8
) (
    input  logic          sysclk,
    input  logic          reset,
    dmem_arbiter_if.slave bus
);
    localparam int unsigned   WW        = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_MAX  = WW'(MAX_WAIT);
    localparam logic [31:0]   MMIO_BASE = 32'h4000_0000;

    logic          cpu_req;
    logic          dma_mmio;
    logic          gnt;
    logic          stall;
    logic [WW-1:0] wait_cnt_q, wait_cnt_d;
    logic          rvalid_q, rvalid_d;
    logic [31:0]   rdata_q, rdata_d;

`ifdef MEM_ARB_BURST_EN
    localparam int unsigned   BW       = $clog2(BURST_LEN + 1);
    localparam logic [BW-1:0] BEAT_MAX = BW'(BURST_LEN);

    typedef enum logic [0:0] {
        S_CPU,
        S_BURST
    } state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] beat_cnt_q, beat_cnt_d;
`else
    logic unused_burst;
    assign unused_burst = bus.dma_burst ^ (BURST_LEN == 0);
`endif

    assign cpu_req  = bus.cpu_rd | bus.cpu_wr;
    assign dma_mmio = (bus.dma_addr >= MMIO_BASE);

    // Grant/stall decode; both are held low while reset is asserted.
    always_comb begin
        gnt   = bus.dma_req & (~cpu_req | (wait_cnt_q == WAIT_MAX));
        stall = gnt & cpu_req;
`ifdef MEM_ARB_BURST_EN
        if (state_q == S_BURST) begin
            gnt   = bus.dma_req;
            stall = cpu_req;
        end
`endif
        if (!reset) begin
            gnt   = 1'b0;
            stall = 1'b0;
        end
    end

    // Memory port mux. A stalled CPU access must not reach memory, since it
    // is replayed unchanged on a later cycle.
    always_comb begin
        bus.mem_addr  = gnt ? bus.dma_addr  : bus.cpu_addr;
        bus.mem_wdata = gnt ? bus.dma_wdata : bus.cpu_wdata;
        bus.mem_rd    = reset & (gnt ? (~bus.dma_we & ~dma_mmio) : (bus.cpu_rd & ~stall));
        bus.mem_wr    = reset & (gnt ? ( bus.dma_we & ~dma_mmio) : (bus.cpu_wr & ~stall));
    end

    assign bus.cpu_rdata  = bus.mem_rdata;
    assign bus.cpu_stall  = stall;
    assign bus.dma_gnt    = gnt;
    assign bus.dma_rvalid = rvalid_q;
    assign bus.dma_rdata  = rdata_q;

    always_comb begin
        wait_cnt_d = '0;
        if (bus.dma_req & ~gnt) begin
            wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;
        end

        rvalid_d = gnt & ~bus.dma_we;
        rdata_d  = rdata_q;
        if (gnt & ~bus.dma_we) begin
            rdata_d = dma_mmio ? '0 : bus.mem_rdata;
        end

`ifdef MEM_ARB_BURST_EN
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            S_CPU: begin
                if (gnt & bus.dma_burst) begin
                    state_d    = S_BURST;
                    beat_cnt_d = BW'(1);
                end
            end
            S_BURST: begin
                // A beat with dma_burst low is still granted but ends the burst.
                if (~bus.dma_req | ~bus.dma_burst) begin
                    state_d    = S_CPU;
                    beat_cnt_d = '0;
                end else if (beat_cnt_q + 1'b1 == BEAT_MAX) begin
                    state_d    = S_CPU;
                    beat_cnt_d = '0;
                end else begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = S_CPU;
                beat_cnt_d = '0;
            end
        endcase
`endif
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            wait_cnt_q <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
`ifdef MEM_ARB_BURST_EN
            state_q    <= S_CPU;
            beat_cnt_q <= '0;
`endif
        end else begin
            wait_cnt_q <= wait_cnt_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
`ifdef MEM_ARB_BURST_EN
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
`endif
        end
    end
endmodule
